bus_arbiter_5: RTL and testbench

Round-robin arbiter that shares one 5-way operand/bus multiplexer among five requesters. It picks at most one requester at a time and holds that grant until the served transaction completes or times out. It drives the mux select directly and exposes a one-hot grant per requester. It sits in front of the shared 5:1 data mux on the memory/peripheral bus path.

---
 rtl/bus_arbiter_5_pkg.sv | 6 +
 rtl/bus_arbiter_5_rr_pick5.sv | 27 ++
 rtl/bus_arbiter_5.sv | 94 +++++++++
 tb/tb_bus_arbiter_5.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_5_pkg.sv
// arb_pkg: shared constants and state type for the 5-way round-robin bus arbiter
package arb_pkg;
    localparam int         NUM_REQ  = 5;
    localparam logic [2:0] SEL_IDLE = 3'd7;
    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;
endpackage

// File: rtl/bus_arbiter_5_rr_pick5.sv
// rr_pick5: combinational round-robin pick, first set req bit scanning from ptr upward with wrap 4->0
//   req   in  5  request vector
//   ptr   in  3  highest-priority index (0..4)
//   found out 1  at least one request present
//   idx   out 3  winning index
module rr_pick5
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         ptr,
    output logic               found,
    output logic [2:0]         idx
);
    // Scan from the lowest priority offset down so the closest-to-ptr hit is assigned last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int j;
            j = (int'(ptr) + k) % NUM_REQ;
            if (req[j]) begin
                found = 1'b1;
                idx   = 3'(j);
            end
        end
    end
endmodule

// File: rtl/bus_arbiter_5.sv
// bus_arbiter_5: round-robin arbiter driving a shared 5:1 mux select with hold-until-done and timeout
//   clk     in  1  system clock
//   rst_n   in  1  synchronous active-low reset
//   req     in  5  per-requester request
//   done    in  1  completion strobe from served slave
//   gnt     out 5  one-hot grant, zero when idle
//   sel     out 3  mux select, 7 when idle
//   busy    out 1  grant held
//   timeout out 1  one-cycle pulse when a grant is revoked by timeout
module bus_arbiter_5
    import arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [2:0]         sel,
    output logic               busy,
    output logic               timeout
);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    arb_state_e         state_q, state_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [2:0]         sel_q, sel_d;
    logic               timeout_q, timeout_d;
    logic               pick_found;
    logic [2:0]         pick_idx;
    logic               expire;

    rr_pick5 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // done has priority over a coinciding expiry, so expiry requires done low.
    assign expire = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST) && !done;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        timeout_d = 1'b0;
        if (state_q == ARB_IDLE) begin
            if (pick_found) begin
                state_d = ARB_GRANT;
                cnt_d   = '0;
                sel_d   = pick_idx;
                gnt_d   = NUM_REQ'(1) << pick_idx;
            end
        end else if (done || expire) begin
            state_d   = ARB_IDLE;
            gnt_d     = '0;
            sel_d     = SEL_IDLE;
            ptr_d     = (sel_q == 3'(NUM_REQ - 1)) ? 3'd0 : sel_q + 3'd1;
            timeout_d = expire;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            sel_q     <= SEL_IDLE;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign busy    = (state_q == ARB_GRANT);
    assign timeout = timeout_q;
endmodule

// File: tb/tb_bus_arbiter_5.sv
// tb_bus_arbiter_5: scoreboard bench for bus_arbiter_5 with TIMEOUT_CYCLES=4
module tb_bus_arbiter_5;
    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       done = 1'b0;
    logic [4:0] req = '0;
    logic [4:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       timeout;

    int n_chk = 0;
    int n_fail = 0;
    logic [9:0] sbq[$];
    int m_busy = 0, m_win = 0, m_ptr = 0, m_cnt = 0, m_to = 0;
    int pat[11] = '{0, 7, 1, 7, 2, 7, 3, 7, 4, 7, 0};

    bus_arbiter_5 #(.TIMEOUT_CYCLES(T)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [4:0] r, input logic d, input logic rn);
        logic [4:0] eg;
        logic [2:0] es;
        if (!rn) begin
            m_busy = 0; m_ptr = 0; m_cnt = 0; m_to = 0; m_win = 0;
        end else begin
            m_to = 0;
            if (m_busy == 0) begin
                for (int k = 0; k < 5; k++) begin
                    int j;
                    j = (m_ptr + k) % 5;
                    if (m_busy == 0 && r[j]) begin
                        m_win = j; m_busy = 1; m_cnt = 0;
                    end
                end
            end else if (d) begin
                m_busy = 0; m_ptr = (m_win + 1) % 5;
            end else if (m_cnt == T - 1) begin
                m_busy = 0; m_ptr = (m_win + 1) % 5; m_to = 1;
            end else begin
                m_cnt++;
            end
        end
        eg = (m_busy != 0) ? 5'(1 << m_win) : 5'd0;
        es = (m_busy != 0) ? 3'(m_win) : 3'd7;
        sbq.push_back({eg, es, 1'(m_busy), 1'(m_to)});
    endtask

    task automatic cyc(input logic [4:0] r, input logic d, input logic rn);
        logic [9:0] e;
        @(negedge clk);
        req = r; done = d; rst_n = rn;
        model(r, d, rn);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check("gnt", 32'(gnt), 32'(e[9:5]));
        check("sel", 32'(sel), 32'(e[4:2]));
        check("busy", 32'(busy), 32'(e[1]));
        check("timeout", 32'(timeout), 32'(e[0]));
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            cyc(5'b11111, 1'b0, 1'b0);
            check("rst_gnt", 32'(gnt), 32'd0);
            check("rst_sel", 32'(sel), 32'd7);
        end
        cyc(5'b11111, 1'b0, 1'b1);
        check("first_gnt", 32'(gnt), 32'b00001);
        check("fair_sel0", 32'(sel), 32'(pat[0]));
        for (int i = 1; i < 11; i++) begin
            cyc(5'b11111, 1'(i % 2), 1'b1);
            check("fair_sel", 32'(sel), 32'(pat[i]));
        end
        cyc(5'b11111, 1'b1, 1'b1);
        cyc(5'b00100, 1'b0, 1'b1);
        cyc(5'b00100, 1'b1, 1'b1);
        cyc(5'b00101, 1'b0, 1'b1);
        check("wrap_sel", 32'(sel), 32'd0);
        cyc(5'b00101, 1'b1, 1'b1);
        cyc(5'b00101, 1'b0, 1'b1);
        check("wrap_next_sel", 32'(sel), 32'd2);
        cyc(5'b00101, 1'b1, 1'b1);
        cyc(5'b00000, 1'b1, 1'b1);
        check("idle_done_busy", 32'(busy), 32'd0);
        cyc(5'b00010, 1'b0, 1'b1);
        check("to_grant_sel", 32'(sel), 32'd1);
        for (int i = 0; i < T - 1; i++) begin
            cyc(5'b00110, 1'b0, 1'b1);
            check("to_hold_busy", 32'(busy), 32'd1);
            check("to_hold_pulse", 32'(timeout), 32'd0);
        end
        cyc(5'b00110, 1'b0, 1'b1);
        check("to_release_busy", 32'(busy), 32'd0);
        check("to_pulse", 32'(timeout), 32'd1);
        cyc(5'b00110, 1'b0, 1'b1);
        check("after_to_sel", 32'(sel), 32'd2);
        check("to_pulse_once", 32'(timeout), 32'd0);
        for (int i = 0; i < T - 1; i++) cyc(5'b00110, 1'b0, 1'b1);
        cyc(5'b00110, 1'b1, 1'b1);
        check("done_vs_to_busy", 32'(busy), 32'd0);
        check("done_vs_to_pulse", 32'(timeout), 32'd0);
        cyc(5'b01000, 1'b0, 1'b1);
        check("drop_grant", 32'(gnt), 32'b01000);
        cyc(5'b10000, 1'b0, 1'b1);
        check("drop_hold_gnt", 32'(gnt), 32'b01000);
        cyc(5'b10000, 1'b1, 1'b1);
        cyc(5'b10000, 1'b0, 1'b1);
        check("drop_next_sel", 32'(sel), 32'd4);
        cyc(5'b10000, 1'b0, 1'b1);
        cyc(5'b10000, 1'b0, 1'b0);
        check("midrst_gnt", 32'(gnt), 32'd0);
        check("midrst_sel", 32'(sel), 32'd7);
        check("midrst_to", 32'(timeout), 32'd0);
        cyc(5'b10001, 1'b0, 1'b1);
        check("post_rst_sel", 32'(sel), 32'd0);
        cyc(5'b10001, 1'b1, 1'b1);
        cyc(5'b10001, 1'b0, 1'b1);
        check("post_rst_next", 32'(sel), 32'd4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
